instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_if.sv | 38 +++
 rtl/instruction_loader.sv | 114 +++++++++++
 tb/tb_instruction_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Byte-stream loader bus: start/receive strobes in, instruction-memory write port and status out.
// o_checksum is present only when LOADER_CHECKSUM_EN is defined.
interface instruction_loader_if #(
  parameter int NBITS     = 8,
  parameter int INST_BITS = 32
);
  logic                 i_start;
  logic [NBITS-1:0]     i_rx_data;
  logic                 i_rx_valid;
  logic [INST_BITS-1:0] o_addr_wr;
  logic [INST_BITS-1:0] o_data;
  logic                 o_wr_en;
  logic                 o_step;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_full;
`ifdef LOADER_CHECKSUM_EN
  logic [INST_BITS-1:0] o_checksum;

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_addr_wr, o_data, o_wr_en, o_step, o_busy, o_done, o_full, o_checksum
  );
  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_addr_wr, o_data, o_wr_en, o_step, o_busy, o_done, o_full, o_checksum
  );
`else
  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_addr_wr, o_data, o_wr_en, o_step, o_busy, o_done, o_full
  );
  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_addr_wr, o_data, o_wr_en, o_step, o_busy, o_done, o_full
  );
`endif
endinterface

// File: rtl/instruction_loader.sv
// Assembles big-endian instruction words from a byte stream and writes them to memory until HALT_WORD or full.
// Optional LOADER_CHECKSUM_EN adds o_checksum, the running sum of written words.
module instruction_loader #(
  parameter int                   NBITS     = 8,
  parameter int                   INST_BITS = 32,
  parameter int                   CELLS     = 256,
  parameter logic [INST_BITS-1:0] HALT_WORD = INST_BITS'(32'hFFFF_FFFF)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  instruction_loader_if.slave  bus
);
  localparam int                   WORD_BYTES = INST_BITS / NBITS;
  localparam int                   CW         = $clog2(WORD_BYTES + 1);
  localparam logic [INST_BITS-1:0] STRIDE     = INST_BITS'(WORD_BYTES);
  localparam logic [INST_BITS-1:0] LIMIT      = INST_BITS'(CELLS);
  localparam logic [CW-1:0]        LAST       = CW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t               state;
  logic [INST_BITS-1:0] addr;
  logic [INST_BITS-1:0] word;
  logic [CW-1:0]        cnt;
  logic [INST_BITS-1:0] word_shift;
  logic [INST_BITS-1:0] addr_next;
  logic [INST_BITS-1:0] csum;

  assign word_shift = {word[INST_BITS-NBITS-1:0], bus.i_rx_data};
  assign addr_next  = addr + STRIDE;

`ifdef LOADER_CHECKSUM_EN
  assign bus.o_checksum = csum;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      addr          <= '0;
      word          <= '0;
      cnt           <= '0;
      csum          <= '0;
      bus.o_addr_wr <= '0;
      bus.o_data    <= '0;
      bus.o_wr_en   <= 1'b0;
      bus.o_step    <= 1'b0;
      bus.o_busy    <= 1'b0;
      bus.o_done    <= 1'b0;
      bus.o_full    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.i_start) begin
            state      <= COLLECT;
            addr       <= '0;
            word       <= '0;
            cnt        <= '0;
            csum       <= '0;
            bus.o_busy <= 1'b1;
            bus.o_done <= 1'b0;
            bus.o_full <= 1'b0;
          end
        end
        COLLECT: begin
          if (bus.i_rx_valid) begin
            word <= word_shift;
            cnt  <= cnt + CW'(1);
            // Write strobe is raised on the same edge that captures the last byte.
            if (cnt == LAST) begin
              state         <= WRITE;
              bus.o_wr_en   <= 1'b1;
              bus.o_step    <= 1'b1;
              bus.o_addr_wr <= addr;
              bus.o_data    <= word_shift;
            end
          end
        end
        WRITE: begin
          bus.o_wr_en <= 1'b0;
          bus.o_step  <= 1'b0;
          addr        <= addr_next;
          csum        <= csum + word;
          if (word == HALT_WORD) begin
            state      <= DONE;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b1;
            bus.o_full <= 1'b0;
          end else if (addr_next == LIMIT) begin
            state      <= DONE;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b1;
            bus.o_full <= 1'b1;
          end else begin
            state <= COLLECT;
            // A byte landing during the write cycle is the first byte of the next word.
            if (bus.i_rx_valid) begin
              word <= INST_BITS'(bus.i_rx_data);
              cnt  <= CW'(1);
            end else begin
              word <= '0;
              cnt  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LOADER_CHECKSUM_EN
  logic unused_csum;
  assign unused_csum = ^csum;
`endif
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized and directed bench for instruction_loader against a byte-stream reference model.
module tb_instruction_loader;
  localparam int NBITS     = 8;
  localparam int INST_BITS = 32;
  localparam int CELLS     = 256;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  instruction_loader_if #(.NBITS(NBITS), .INST_BITS(INST_BITS)) bus();

  instruction_loader #(
    .NBITS(NBITS), .INST_BITS(INST_BITS), .CELLS(CELLS), .HALT_WORD(HALT)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [63:0] wq[$];
  logic [7:0]  stim[$];
  logic [63:0] exp_q[$];
  logic        exp_full;
  logic [31:0] exp_sum;
  bit          exp_ends;

  // Observe memory writes mid-cycle, as a falling-edge memory would.
  always @(negedge i_clk) begin
    check("step_eq_wr_en", 64'(bus.o_step), 64'(bus.o_wr_en));
    if (!i_rst) check("wr_en_in_reset", 64'(bus.o_wr_en), 64'd0);
    if (bus.o_wr_en) begin
      check("addr_in_range", 64'(bus.o_addr_wr < CELLS), 64'd1);
      wq.push_back({bus.o_addr_wr, bus.o_data});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Every byte after start is consumed until the load terminates; the rest are dropped.
  task automatic model();
    logic [31:0] w;
    exp_q.delete();
    exp_full = 1'b0;
    exp_sum  = '0;
    exp_ends = 1'b0;
    for (int k = 0; (4*k + 3 < stim.size()) && !exp_ends; k++) begin
      w = {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
      exp_q.push_back({32'(4*k), w});
      exp_sum += w;
      if (w == HALT) begin
        exp_ends = 1'b1;
        exp_full = 1'b0;
      end else if (4*k + 4 == CELLS) begin
        exp_ends = 1'b1;
        exp_full = 1'b1;
      end
    end
  endtask

  task automatic run_load(input string tag, input int maxgap, input bit start_pulse);
    int nterm;
    int start_at;
    model();
    nterm    = exp_q.size();
    start_at = (start_pulse && nterm > 0) ? int'($urandom_range(1, 4*nterm - 1)) : -1;
    wq.delete();
    pulse_start();
    for (int i = 0; i < stim.size(); i++) begin
      if (maxgap == 0 && i > 0 && (i % 4) == 0 && i < 4*nterm)
        check({tag, "_byte_in_write_cycle"}, 64'(bus.o_wr_en), 64'd1);
      bus.i_start    = (i == start_at);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = stim[i];
      tick();
      bus.i_start    = 1'b0;
      bus.i_rx_valid = 1'b0;
      repeat ($urandom_range(0, maxgap)) tick();
    end
    for (int c = 0; c < 40 && !bus.o_done; c++) tick();
    tick();
    check({tag, "_done"}, 64'(bus.o_done), 64'd1);
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    check({tag, "_full"}, 64'(bus.o_full), 64'(exp_full));
    check({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      check($sformatf("%s_write%0d", tag, i), wq[i], exp_q[i]);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 64'(bus.o_checksum), 64'(exp_sum));
`endif
  endtask

  initial begin
    logic [31:0] last_addr;
    int nw;
    int h;
    bit use_halt;

    bus.i_start    = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    #1 i_rst = 1'b0;
    repeat (2) tick();
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_full", 64'(bus.o_full), 64'd0);
    check("rst_addr", 64'(bus.o_addr_wr), 64'd0);
    check("rst_data", 64'(bus.o_data), 64'd0);
    check("rst_wr_en", 64'(bus.o_wr_en), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_checksum", 64'(bus.o_checksum), 64'd0);
`endif
    i_rst = 1'b1;
    tick();

    // Halt-terminated load, then bytes in DONE must be ignored.
    stim = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load("halt", 1, 1'b0);
    check("halt_first_word", wq.size() > 0 ? wq[0] : 64'd0, {32'd0, 32'h8C01_0004});
`ifdef LOADER_CHECKSUM_EN
    check("halt_checksum_const", 64'(bus.o_checksum), 64'h8C01_0003);
`endif
    last_addr = bus.o_addr_wr;
    for (int i = 0; i < 6; i++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'($urandom);
      tick();
    end
    bus.i_rx_valid = 1'b0;
    tick();
    check("done_bytes_nwrites", 64'(wq.size()), 64'd2);
    check("done_bytes_done", 64'(bus.o_done), 64'd1);
    check("done_bytes_addr", 64'(bus.o_addr_wr), 64'(last_addr));

    // Fill to capacity, with trailing bytes that must be dropped.
    stim.delete();
    repeat (CELLS + 4) stim.push_back(8'h11);
    run_load("full", 1, 1'b0);

    // Back-to-back bytes put the first byte of a word in the write cycle.
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load("b2b", 0, 1'b0);
    check("b2b_second_word", wq.size() > 1 ? wq[1] : 64'd0, {32'd4, 32'hAABB_CCDD});

    // Reset mid-load aborts it; a fresh load starts from address 0.
    wq.delete();
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = 8'h5A;
      tick();
    end
    bus.i_rx_valid = 1'b0;
    #2 i_rst = 1'b0;
    #1;
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    check("abort_data", 64'(bus.o_data), 64'd0);
    check("abort_addr", 64'(bus.o_addr_wr), 64'd0);
    repeat (3) tick();
    check("abort_nwrites", 64'(wq.size()), 64'd0);
    i_rst = 1'b1;
    tick();
    stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load("after_rst", 2, 1'b0);

    // Start pulsed mid-load must not restart it.
    stim = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load("start_in_collect", 1, 1'b1);

    for (int l = 0; l < 6; l++) begin
      use_halt = ($urandom_range(0, 9) < 7);
      h  = $urandom_range(0, 63);
      nw = use_halt ? h + 1 + int'($urandom_range(0, 3)) : 64 + int'($urandom_range(0, 2));
      stim.delete();
      for (int i = 0; i < 4*nw; i++)
        stim.push_back((use_halt && (i / 4) == h) ? 8'hFF : 8'($urandom));
      run_load($sformatf("rand%0d", l), (l % 3), (l % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
